// File: rtl/cdb_arbiter.sv
// Writeback packet type and the Common Data Bus arbiter: picks up to two of four
// pending writeback requests per cycle in round-robin order and registers them onto the CDB.
package uarch_pkg;
    typedef struct packed {
        logic        is_valid;
        logic        has_exception;
        logic [5:0]  rob_tag;
        logic [6:0]  phys_reg;
        logic [31:0] data;
    } writeback_packet_t;
endpackage

module cdb_arbiter
    import uarch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  writeback_packet_t alu_result0,
    input  writeback_packet_t alu_result1,
    input  writeback_packet_t mdu_result,
    input  writeback_packet_t dcache_result,
    output logic              alu_cdb_gnt0,
    output logic              alu_cdb_gnt1,
    output logic              mdu_cdb_gnt,
    output logic              dcache_cdb_gnt,
    output writeback_packet_t cdb_port0,
    output writeback_packet_t cdb_port1
);
    logic [1:0]        rr_ptr;
    writeback_packet_t req_pkt [4];
    logic [3:0]        req_valid;
    logic [3:0]        gnt;
    logic              slot0_hit, slot1_hit;
    logic [1:0]        slot0_idx, slot1_idx;
    logic [1:0]        cand;

    assign req_pkt[0] = alu_result0;
    assign req_pkt[1] = alu_result1;
    assign req_pkt[2] = mdu_result;
    assign req_pkt[3] = dcache_result;

    assign req_valid = {dcache_result.is_valid, mdu_result.is_valid,
                        alu_result1.is_valid, alu_result0.is_valid};

    // Walk the requesters starting at rr_ptr; first hit takes slot 0, second takes slot 1.
    always_comb begin
        slot0_hit = 1'b0;
        slot1_hit = 1'b0;
        slot0_idx = 2'd0;
        slot1_idx = 2'd0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + k[1:0];
            if (req_valid[cand]) begin
                if (!slot0_hit) begin
                    slot0_hit = 1'b1;
                    slot0_idx = cand;
                end else if (!slot1_hit) begin
                    slot1_hit = 1'b1;
                    slot1_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (!rst && !flush) begin
            if (slot0_hit) gnt[slot0_idx] = 1'b1;
            if (slot1_hit) gnt[slot1_idx] = 1'b1;
        end
    end

    assign alu_cdb_gnt0   = gnt[0];
    assign alu_cdb_gnt1   = gnt[1];
    assign mdu_cdb_gnt    = gnt[2];
    assign dcache_cdb_gnt = gnt[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= 2'd0;
            cdb_port0 <= '0;
            cdb_port1 <= '0;
        end else if (flush) begin
            cdb_port0 <= '0;
            cdb_port1 <= '0;
        end else begin
            cdb_port0 <= slot0_hit ? req_pkt[slot0_idx] : '0;
            cdb_port1 <= slot1_hit ? req_pkt[slot1_idx] : '0;
            // Priority moves just past the last requester served this cycle.
            if (slot1_hit)
                rr_ptr <= slot1_idx + 2'd1;
            else if (slot0_hit)
                rr_ptr <= slot0_idx + 2'd1;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized checks for cdb_arbiter: grants, port contents,
// round-robin pointer movement, flush, reset and bounded waiting.
module tb_cdb_arbiter;
    import uarch_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    writeback_packet_t alu0_r, alu1_r, mdu_r, dc_r;
    logic              gnt_a0, gnt_a1, gnt_mdu, gnt_dc;
    writeback_packet_t port0, port1;
    wire  [3:0]        gnt_vec = {gnt_dc, gnt_mdu, gnt_a1, gnt_a0};

    int total = 0;
    int bad   = 0;
    int seq   = 0;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .alu_result0   (alu0_r),
        .alu_result1   (alu1_r),
        .mdu_result    (mdu_r),
        .dcache_result (dc_r),
        .alu_cdb_gnt0  (gnt_a0),
        .alu_cdb_gnt1  (gnt_a1),
        .mdu_cdb_gnt   (gnt_mdu),
        .dcache_cdb_gnt(gnt_dc),
        .cdb_port0     (port0),
        .cdb_port1     (port1)
    );

    function automatic writeback_packet_t mk(input int s, input int n);
        writeback_packet_t p;
        p               = '0;
        p.is_valid      = 1'b1;
        p.has_exception = n[0];
        p.rob_tag       = n[5:0];
        p.phys_reg      = 7'(s * 16 + (n % 16));
        p.data          = 32'(s << 28) | 32'(n);
        return p;
    endfunction

    task automatic drive(input writeback_packet_t p0, input writeback_packet_t p1,
                         input writeback_packet_t p2, input writeback_packet_t p3);
        alu0_r = p0;
        alu1_r = p1;
        mdu_r  = p2;
        dc_r   = p3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(mk(0, 1), mk(1, 2), mk(2, 3), mk(3, 4));
        step();
        step();
        total++;
        if (gnt_vec !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt_vec, 4'b0000);
        end
        total++;
        if (port0 !== writeback_packet_t'('0) || port1 !== writeback_packet_t'('0)) begin
            bad++; $display("FAIL reset_ports got=%h/%h exp=0/0", port0, port1);
        end
        total++;
        if (dut.rr_ptr !== 2'd0) begin
            bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.rr_ptr);
        end
        rst = 1'b0;
        drive('0, '0, '0, '0);
        step();
    endtask

    task automatic test_single();
        writeback_packet_t a;
        a = mk(0, 10);
        drive(a, '0, '0, '0);
        #1;
        total++;
        if (gnt_vec !== 4'b0001) begin
            bad++; $display("FAIL single_gnt got=%b exp=%b", gnt_vec, 4'b0001);
        end
        step();
        drive('0, '0, '0, '0);
        total++;
        if (port0 !== a || port1.is_valid !== 1'b0) begin
            bad++; $display("FAIL single_ports got=%h/%b exp=%h/0", port0, port1.is_valid, a);
        end
        total++;
        if (dut.rr_ptr !== 2'd1) begin
            bad++; $display("FAIL single_ptr got=%0d exp=1", dut.rr_ptr);
        end
    endtask

    task automatic test_all_four();
        writeback_packet_t p0, p1, p2, p3;
        drive('0, '0, '0, mk(3, 20));
        #1;
        total++;
        if (gnt_vec !== 4'b1000) begin
            bad++; $display("FAIL lone_dc_gnt got=%b exp=%b", gnt_vec, 4'b1000);
        end
        step();
        total++;
        if (dut.rr_ptr !== 2'd0) begin
            bad++; $display("FAIL lone_dc_ptr got=%0d exp=0", dut.rr_ptr);
        end
        p0 = mk(0, 21); p1 = mk(1, 22); p2 = mk(2, 23); p3 = mk(3, 24);
        drive(p0, p1, p2, p3);
        #1;
        total++;
        if (gnt_vec !== 4'b0011) begin
            bad++; $display("FAIL all4_c0_gnt got=%b exp=%b", gnt_vec, 4'b0011);
        end
        step();
        total++;
        if (port0 !== p0 || port1 !== p1) begin
            bad++; $display("FAIL all4_c0_ports got=%h/%h exp=%h/%h", port0, port1, p0, p1);
        end
        total++;
        if (dut.rr_ptr !== 2'd2) begin
            bad++; $display("FAIL all4_c0_ptr got=%0d exp=2", dut.rr_ptr);
        end
        drive(mk(0, 25), mk(1, 26), p2, p3);
        #1;
        total++;
        if (gnt_vec !== 4'b1100) begin
            bad++; $display("FAIL all4_c1_gnt got=%b exp=%b", gnt_vec, 4'b1100);
        end
        step();
        drive('0, '0, '0, '0);
        total++;
        if (port0 !== p2 || port1 !== p3) begin
            bad++; $display("FAIL all4_c1_ports got=%h/%h exp=%h/%h", port0, port1, p2, p3);
        end
        total++;
        if (dut.rr_ptr !== 2'd0) begin
            bad++; $display("FAIL all4_c1_ptr got=%0d exp=0", dut.rr_ptr);
        end
        step();
        total++;
        if (port0.is_valid !== 1'b0 || port1.is_valid !== 1'b0) begin
            bad++; $display("FAIL idle_ports got=%b%b exp=00", port0.is_valid, port1.is_valid);
        end
    endtask

    task automatic test_wrap();
        writeback_packet_t d, a1;
        drive('0, '0, mk(2, 30), '0);
        #1;
        total++;
        if (gnt_vec !== 4'b0100) begin
            bad++; $display("FAIL lone_mdu_gnt got=%b exp=%b", gnt_vec, 4'b0100);
        end
        step();
        total++;
        if (dut.rr_ptr !== 2'd3) begin
            bad++; $display("FAIL lone_mdu_ptr got=%0d exp=3", dut.rr_ptr);
        end
        d  = mk(3, 31);
        a1 = mk(1, 32);
        drive('0, a1, '0, d);
        #1;
        total++;
        if (gnt_vec !== 4'b1010) begin
            bad++; $display("FAIL wrap_gnt got=%b exp=%b", gnt_vec, 4'b1010);
        end
        step();
        total++;
        if (port0 !== d || port1 !== a1) begin
            bad++; $display("FAIL wrap_ports got=%h/%h exp=%h/%h", port0, port1, d, a1);
        end
        total++;
        if (dut.rr_ptr !== 2'd2) begin
            bad++; $display("FAIL wrap_ptr got=%0d exp=2", dut.rr_ptr);
        end
    endtask

    task automatic test_flush();
        writeback_packet_t a0, a1, m;
        a0 = mk(0, 40); a1 = mk(1, 41); m = mk(2, 42);
        drive(a0, a1, m, '0);
        flush = 1'b1;
        #1;
        total++;
        if (gnt_vec !== 4'b0000) begin
            bad++; $display("FAIL flush_gnt got=%b exp=%b", gnt_vec, 4'b0000);
        end
        step();
        flush = 1'b0;
        total++;
        if (port0.is_valid !== 1'b0 || port1.is_valid !== 1'b0) begin
            bad++; $display("FAIL flush_ports got=%b%b exp=00", port0.is_valid, port1.is_valid);
        end
        total++;
        if (dut.rr_ptr !== 2'd2) begin
            bad++; $display("FAIL flush_ptr got=%0d exp=2", dut.rr_ptr);
        end
        #1;
        total++;
        if (gnt_vec !== 4'b0101) begin
            bad++; $display("FAIL post_flush_gnt got=%b exp=%b", gnt_vec, 4'b0101);
        end
        step();
        total++;
        if (port0 !== m || port1 !== a0) begin
            bad++; $display("FAIL post_flush_ports got=%h/%h exp=%h/%h", port0, port1, m, a0);
        end
        total++;
        if (dut.rr_ptr !== 2'd1) begin
            bad++; $display("FAIL post_flush_ptr got=%0d exp=1", dut.rr_ptr);
        end
    endtask

    task automatic test_rst_mid();
        drive('0, mk(1, 41), '0, mk(3, 50));
        rst = 1'b1;
        #1;
        total++;
        if (gnt_vec !== 4'b0000) begin
            bad++; $display("FAIL rst_mid_gnt got=%b exp=%b", gnt_vec, 4'b0000);
        end
        step();
        total++;
        if (port0 !== writeback_packet_t'('0) || port1 !== writeback_packet_t'('0)) begin
            bad++; $display("FAIL rst_mid_ports got=%h/%h exp=0/0", port0, port1);
        end
        total++;
        if (dut.rr_ptr !== 2'd0) begin
            bad++; $display("FAIL rst_mid_ptr got=%0d exp=0", dut.rr_ptr);
        end
        rst = 1'b0;
        drive('0, '0, '0, '0);
        step();
    endtask

    task automatic test_random();
        writeback_packet_t src [4];
        writeback_packet_t prev [4];
        logic [3:0] prev_g, g, v;
        int waitc [4];
        int nv, ng, exp_ng;
        prev_g = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src[i] = '0; prev[i] = '0; waitc[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            step();
            ng = $countones(prev_g);
            total++;
            if ({port1.is_valid, port0.is_valid} !== (ng == 0 ? 2'b00 : ng == 1 ? 2'b01 : 2'b11)) begin
                bad++; $display("FAIL rnd_port_valid cyc=%0d got=%b%b grants=%0d", c, port1.is_valid, port0.is_valid, ng);
            end
            for (int i = 0; i < 4; i++) begin
                if (prev_g[i]) begin
                    total++;
                    if (port0 !== prev[i] && port1 !== prev[i]) begin
                        bad++; $display("FAIL rnd_broadcast cyc=%0d src=%0d got=%h/%h exp=%h", c, i, port0, port1, prev[i]);
                    end
                end
                if (prev_g[i] || !src[i].is_valid) begin
                    if ($urandom_range(0, 3) != 0) begin
                        seq++;
                        src[i] = mk(i, seq);
                    end else begin
                        src[i] = '0;
                    end
                end
            end
            drive(src[0], src[1], src[2], src[3]);
            #1;
            g  = gnt_vec;
            v  = {src[3].is_valid, src[2].is_valid, src[1].is_valid, src[0].is_valid};
            nv = $countones(v);
            exp_ng = (nv > 2) ? 2 : nv;
            total++;
            if ((g & ~v) != 4'b0000 || $countones(g) != exp_ng) begin
                bad++; $display("FAIL rnd_grant cyc=%0d got=%b valid=%b exp_count=%0d", c, g, v, exp_ng);
            end
            for (int i = 0; i < 4; i++) begin
                if (v[i] && !g[i]) begin
                    waitc[i]++;
                    total++;
                    if (waitc[i] > 1) begin
                        bad++; $display("FAIL rnd_starve cyc=%0d src=%0d waited=%0d max=1", c, i, waitc[i]);
                    end
                end else begin
                    waitc[i] = 0;
                end
                prev[i] = src[i];
            end
            prev_g = g;
        end
        drive('0, '0, '0, '0);
        step();
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive('0, '0, '0, '0);
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter directly downstream of the execute unit. Each cycle it takes up to four pending writeback packets (ALU0, ALU1, MDU, DCACHE) and grants at most two of them with a round-robin policy. It drives the two registered CDB broadcast ports consumed by the ROB, the reservation stations, and the execute forwarding inputs. Sources hold their packet until granted; the arbiter never drops or reorders a granted packet.

## Interface
- Parameters: none. Packet type and widths come from `uarch_pkg` (`writeback_packet_t`).
- Requester index is fixed: 0 = ALU0, 1 = ALU1, 2 = MDU, 3 = DCACHE.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  pipeline flush from ROB.
- `alu_result0`  in  `writeback_packet_t`  ALU0 request; a request is pending while its `is_valid` field is 1.
- `alu_result1`  in  `writeback_packet_t`  ALU1 request.
- `mdu_result`  in  `writeback_packet_t`  MDU request.
- `dcache_result`  in  `writeback_packet_t`  load-result request.
- `alu_cdb_gnt0`, `alu_cdb_gnt1`, `mdu_cdb_gnt`, `dcache_cdb_gnt`  out  1 each  combinational same-cycle grants.
- `cdb_port0`, `cdb_port1`  out  `writeback_packet_t`  registered CDB broadcasts.

## Operation
- **Round-robin pointer `rr_ptr`** (2 bits) gives the highest-priority index.
  - Search order: `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, `rr_ptr+3`, all mod 4.
- **Grant selection.**
  - The first valid requester in search order wins slot 0 and goes to `cdb_port0`.
  - The second valid requester wins slot 1 and goes to `cdb_port1`.
  - At most 2 grants are asserted per cycle; the remaining requesters wait.
- **Pointer update.** If ≥1 grant was given, `rr_ptr` becomes (index of the last granted requester + 1) mod 4. Otherwise it is unchanged.
  - Wrap-around: last granted = 3 gives `rr_ptr` = 0.
- **Output register.** Granted packets are copied field-for-field into the port registers; only the valid field is interpreted.
  - If a slot is unused, that port's register has `is_valid` = 0; the other fields are don't-care but are driven to 0.
  - One granted packet always goes to `cdb_port0`. `cdb_port1` is never valid while `cdb_port0` is invalid.
- **Grant signals.** A grant is asserted only when its requester's `is_valid` = 1.
  - The source treats the packet as consumed on the clock edge with grant = 1. It may present a new packet in the next cycle.
- **Flush** takes priority over arbitration:
  - All grants are 0 in the flush cycle.
  - Both port registers load `is_valid` = 0 at that edge.
  - `rr_ptr` is unchanged.
  - Pending requests remain the sources' responsibility to drop.
- **Reset.** On `rst` = 1 at the edge:
  - `rr_ptr` ← 0.
  - Both port registers ← all-zero (`is_valid` = 0).
  - Grants are forced to 0 while `rst` = 1.
  - Reset mid-stream discards any in-flight broadcast.
- **Guarantee.** No starvation: a continuously valid requester is granted within 2 cycles.

## Timing
- Request valid in cycle N produces a combinational grant in cycle N.
- The packet appears on `cdb_port*` in cycle N+1, valid for exactly one cycle. Latency is 1 cycle.
- Grants depend only on the current-cycle request valids, `rr_ptr`, `flush`, and `rst`. There is no combinational path from `cdb_port*` to the grants.
- Throughput is 2 packets per cycle sustained.
- Reset values:
  - grants: 0
  - `cdb_port0`.`is_valid` = 0, `cdb_port1`.`is_valid` = 0
  - `rr_ptr` = 0
- A source that drops `is_valid` before being granted simply withdraws its request. This is legal and produces no grant and no broadcast.

## Test plan
- **Reset, then single request:** ALU0 valid only.
  - Cycle N: `alu_cdb_gnt0` = 1.
  - Cycle N+1: `cdb_port0` = ALU0 packet, `cdb_port1` invalid.
  - `rr_ptr` becomes 1.
- **All four valid and held, starting from `rr_ptr` = 0:**
  - Cycle 0 grants {ALU0 → port0, ALU1 → port1}, `rr_ptr` = 2.
  - Cycle 1 grants {MDU → port0, DCACHE → port1}, `rr_ptr` = 0.
  - Every packet appears exactly once, one cycle after its grant.
- **Wrap-around, `rr_ptr` = 3, DCACHE and ALU1 valid:**
  - Port0 = DCACHE, port1 = ALU1.
  - `rr_ptr` = 2.
- **Flush while 3 requests are valid:**
  - All grants are 0.
  - Next cycle both ports are invalid.
  - `rr_ptr` is unchanged.
  - Deassert flush: arbitration resumes from the old pointer.
- **`rst` asserted while ports hold valid packets:**
  - Next cycle both ports are invalid, `rr_ptr` = 0, and no grants are given during reset.
- **Random request streams, 10k cycles, scoreboard:**
  - Every granted packet is broadcast exactly once.
  - Never more than 2 grants per cycle.
  - Maximum wait of a continuously valid requester is ≤ 2 cycles.
